// File: rtl/seg_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_pkg
// Description : Shared types, display constants and helpers for the
//               seven-segment display scheduler.
// Revision    : 1.0  initial release
// ============================================================================
package seg_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_SHOW    = 2'd2
    } state_t;

    localparam int BCD_DIGITS = 4;
    localparam int MAX_DEC    = 9999;

    // Segment codes {a,b,c,d,e,f,g}, active low
    localparam logic [6:0] SEG_0   = 7'b0000001;
    localparam logic [6:0] SEG_1   = 7'b1001111;
    localparam logic [6:0] SEG_2   = 7'b0010010;
    localparam logic [6:0] SEG_3   = 7'b0000110;
    localparam logic [6:0] SEG_4   = 7'b1001100;
    localparam logic [6:0] SEG_5   = 7'b0100100;
    localparam logic [6:0] SEG_6   = 7'b0100000;
    localparam logic [6:0] SEG_7   = 7'b0001111;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0000100;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam logic [3:0] AN_THOUSANDS = 4'b0111;
    localparam logic [3:0] AN_HUNDREDS  = 4'b1011;
    localparam logic [3:0] AN_TENS      = 4'b1101;
    localparam logic [3:0] AN_ONES      = 4'b1110;
    localparam logic [3:0] AN_OFF       = 4'b1111;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_0;
        endcase
        return code;
    endfunction

    // Four BCD digits cannot represent more than MAX_DEC
    function automatic logic [31:0] clamp_dec(input logic [31:0] value);
        return (value > 32'(MAX_DEC)) ? 32'(MAX_DEC) : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_seq_converter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_seq_converter
// Description : Sequential shift-add-3 binary to 4-digit BCD converter,
//               one bit per cycle, single-cycle done pulse.
// Revision    : 1.0  initial release
// ============================================================================
module bcd_seq_converter
    import seg_display_pkg::*;
#(
    parameter int VAL_W = 13
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [VAL_W-1:0]          bin,
    output logic                      done,
    output logic [BCD_DIGITS*4-1:0]   bcd
);

    localparam int BCD_W = BCD_DIGITS * 4;
    localparam int CNT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;

    logic [VAL_W-1:0] r_bin;
    logic [BCD_W-1:0] r_bcd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [BCD_W-1:0] w_adj;

    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_nibble
        assign w_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ? r_bcd[gi*4 +: 4] + 4'd3
                                                            : r_bcd[gi*4 +: 4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_bin  <= bin;
                r_bcd  <= '0;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                {r_bcd, r_bin} <= {w_adj[BCD_W-2:0], r_bin, 1'b0};
                r_cnt          <= r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(VAL_W - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done = r_done;
    assign bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/seg_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_scheduler
// Description : Round-robin sharing of a 4-digit seven-segment display between
//               several value sources, with BCD conversion and digit scanning.
// Revision    : 1.0  initial release
// ============================================================================
module seg_display_scheduler
    import seg_display_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int VAL_W        = 13,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int REFRESH_BITS = 20,
    localparam int SRC_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC-1:0]       src_valid,
    input  logic [NUM_SRC*VAL_W-1:0] src_value,
    output logic [NUM_SRC-1:0]       src_ack,
    output logic [SRC_W-1:0]         cur_src,
    output logic [3:0]               Anode,
    output logic [6:0]               LED_out
);

    localparam int DW_W  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int BCD_W = BCD_DIGITS * 4;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [SRC_W-1:0]        r_rr_ptr;
    logic [SRC_W-1:0]        r_cur_src;
    logic [NUM_SRC-1:0]      r_ack;
    logic [DW_W-1:0]         r_dwell;
    logic [BCD_W-1:0]        r_digits;
    logic                    r_blank;
    logic [REFRESH_BITS-1:0] r_refresh;
    logic [3:0]              r_anode;
    logic [6:0]              r_led;

    logic [SRC_W:0]          w_pick;
    logic                    w_any;
    logic [SRC_W-1:0]        w_grant;
    logic [VAL_W-1:0]        w_value;
    logic [VAL_W-1:0]        w_clamped;
    logic                    w_fire;
    logic                    w_dwell_end;
    logic                    w_conv_done;
    logic [BCD_W-1:0]        w_conv_bcd;
    logic [SRC_W-1:0]        w_ptr_next;
    logic [1:0]              w_sel;
    logic [3:0]              w_scan_anode;
    logic [3:0]              w_scan_digit;

    // Returns {found, index} of the first valid source at or after ptr
    function automatic logic [SRC_W:0] rr_pick(input logic [NUM_SRC-1:0] valid,
                                               input logic [SRC_W-1:0]   ptr);
        logic [SRC_W:0] res;
        int             idx;
        res = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_SRC;
            if (valid[SRC_W'(idx)]) res = {1'b1, SRC_W'(idx)};
        end
        return res;
    endfunction

    assign w_pick     = rr_pick(src_valid, r_rr_ptr);
    assign w_any      = w_pick[SRC_W];
    assign w_grant    = w_pick[SRC_W-1:0];
    assign w_value    = src_value[w_grant*VAL_W +: VAL_W];
    assign w_clamped  = VAL_W'(clamp_dec(32'(w_value)));
    assign w_ptr_next = (r_cur_src == SRC_W'(NUM_SRC - 1)) ? '0 : r_cur_src + SRC_W'(1);

    bcd_seq_converter #(
        .VAL_W (VAL_W)
    ) u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (w_fire),
        .bin   (w_clamped),
        .done  (w_conv_done),
        .bcd   (w_conv_bcd)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_fire       = 1'b0;
        w_dwell_end  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_fire       = 1'b1;
                    w_next_state = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (w_conv_done) w_next_state = ST_SHOW;
            end
            ST_SHOW: begin
                if (r_dwell == DW_W'(DWELL_CYCLES - 1)) begin
                    w_dwell_end  = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_cur_src <= '0;
            r_ack     <= '0;
            r_dwell   <= '0;
            r_digits  <= '0;
            r_blank   <= 1'b1;
        end else begin
            r_ack <= '0;
            if (w_fire) begin
                r_cur_src <= w_grant;
                r_ack     <= NUM_SRC'(1) << w_grant;
            end
            // Digits change only when a fresh conversion completes
            if (r_state == ST_CONVERT && w_conv_done) begin
                r_digits <= w_conv_bcd;
                r_blank  <= 1'b0;
                r_dwell  <= '0;
            end else if (r_state == ST_SHOW) begin
                r_dwell <= r_dwell + DW_W'(1);
            end
            if (w_dwell_end) r_rr_ptr <= w_ptr_next;
        end
    end

    assign w_sel = r_refresh[REFRESH_BITS-1 -: 2];

    always_comb begin
        w_scan_anode = AN_OFF;
        w_scan_digit = '0;
        case (w_sel)
            2'b00: begin w_scan_anode = AN_THOUSANDS; w_scan_digit = r_digits[15:12]; end
            2'b01: begin w_scan_anode = AN_HUNDREDS;  w_scan_digit = r_digits[11:8];  end
            2'b10: begin w_scan_anode = AN_TENS;      w_scan_digit = r_digits[7:4];   end
            default: begin w_scan_anode = AN_ONES;    w_scan_digit = r_digits[3:0];   end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh <= '0;
            r_anode   <= AN_OFF;
            r_led     <= SEG_OFF;
        end else begin
            r_refresh <= r_refresh + REFRESH_BITS'(1);
            r_anode   <= r_blank ? AN_OFF  : w_scan_anode;
            r_led     <= r_blank ? SEG_OFF : seg_decode(w_scan_digit);
        end
    end

    assign src_ack = r_ack;
    assign cur_src = r_cur_src;
    assign Anode   = r_anode;
    assign LED_out = r_led;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_display_scheduler
// Description : Self-checking bench: timeline model of the display scheduler
//               plus directed scenarios with literal expectations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seg_display_scheduler;
    import seg_display_pkg::*;

    localparam int N  = 4;
    localparam int W  = 13;
    localparam int DW = 40;
    localparam int RB = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] src_valid = '0;
    logic [N*W-1:0] src_value = '0;
    logic [N-1:0] src_ack;
    logic [1:0]   cur_src;
    logic [3:0]   Anode;
    logic [6:0]   LED_out;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    seg_display_scheduler #(
        .NUM_SRC      (N),
        .VAL_W        (W),
        .DWELL_CYCLES (DW),
        .REFRESH_BITS (RB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_value (src_value),
        .src_ack   (src_ack),
        .cur_src   (cur_src),
        .Anode     (Anode),
        .LED_out   (LED_out)
    );

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Timeline model: a granted value occupies 14 cycles of conversion then DW of display
    logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    int  m_timer, m_ptr, m_refresh, m_pending, m_sel, m_idx, m_g, m_val;
    int  m_digits [4];
    bit  m_blank, m_found;
    bit  model_live = 1'b0;
    logic [3:0]   exp_anode;
    logic [6:0]   exp_led;
    logic [N-1:0] exp_ack;
    int           exp_cur;

    always @(posedge clk) begin
        if (rst) begin
            m_timer = 0; m_ptr = 0; m_refresh = 0; m_blank = 1'b1;
            for (int i = 0; i < 4; i++) m_digits[i] = 0;
            exp_anode = 4'hF; exp_led = 7'h7F; exp_ack = '0; exp_cur = 0;
            model_live = 1'b1;
        end else begin
            m_sel = m_refresh >> (RB - 2);
            if (m_blank) begin
                exp_anode = 4'hF; exp_led = 7'h7F;
            end else begin
                exp_anode = ~(4'b1000 >> m_sel);
                exp_led   = seg_tab[m_digits[m_sel]];
            end
            m_refresh = (m_refresh + 1) % (1 << RB);
            exp_ack = '0;
            if (m_timer == 0) begin
                m_found = 1'b0; m_g = 0;
                for (int k = 0; k < N; k++) begin
                    m_idx = (m_ptr + k) % N;
                    if (!m_found && src_valid[m_idx]) begin m_found = 1'b1; m_g = m_idx; end
                end
                if (m_found) begin
                    m_val     = int'(src_value[m_g*W +: W]);
                    m_pending = (m_val > 9999) ? 9999 : m_val;
                    exp_cur   = m_g;
                    exp_ack   = N'(1) << m_g;
                    m_timer   = 14 + DW;
                end
            end else begin
                m_timer--;
                if (m_timer == DW) begin
                    m_digits[0] = m_pending / 1000;
                    m_digits[1] = (m_pending / 100) % 10;
                    m_digits[2] = (m_pending / 10) % 10;
                    m_digits[3] = m_pending % 10;
                    m_blank = 1'b0;
                end
                if (m_timer == 0) m_ptr = (exp_cur + 1) % N;
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("model_anode", int'(Anode), int'(exp_anode));
            check("model_led", int'(LED_out), int'(exp_led));
            check("model_ack", int'(src_ack), int'(exp_ack));
            check("model_cur_src", int'(cur_src), exp_cur);
        end
    end

    task automatic set_val(input int s, input int v);
        src_value[s*W +: W] = W'(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; src_valid = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ack(input string nm, output int idx, output int t);
        idx = -1; t = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (src_ack != '0) begin
                for (int b = 0; b < N; b++) if (src_ack[b]) idx = b;
                t = cyc;
                break;
            end
        end
        check({nm, "_ack_seen"}, int'(idx >= 0), 1);
    endtask

    task automatic expect_digit(input string nm, input logic [3:0] an, input logic [6:0] led);
        bit hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (Anode == an) hit = 1'b1;
        end
        check({nm, "_anode_seen"}, int'(hit), 1);
        check({nm, "_led"}, int'(LED_out), int'(led));
    endtask

    int idx, t, t_prev, acks;

    initial begin
        // Reset and idle blank
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_anode", int'(Anode), 4'hF);
        check("rst_led", int'(LED_out), 7'h7F);
        check("rst_ack", int'(src_ack), 0);
        repeat (20) @(negedge clk);
        check("idle_blank_anode", int'(Anode), 4'hF);

        // Single source, value 1234
        set_val(0, 1234);
        src_valid = 4'b0001;
        wait_ack("t1", idx, t);
        check("t1_ack_vec", int'(src_ack), 4'b0001);
        @(negedge clk);
        src_valid = '0;
        check("t1_ack_one_cycle", int'(src_ack), 0);
        repeat (13) @(negedge clk);
        check("t1_still_blank", int'(Anode), 4'hF);
        @(negedge clk);
        check("t1_digits_live", int'(Anode != 4'hF), 1);
        expect_digit("t1_thou", 4'b0111, 7'b1001111);
        expect_digit("t1_hund", 4'b1011, 7'b0010010);
        expect_digit("t1_tens", 4'b1101, 7'b0000110);
        expect_digit("t1_ones", 4'b1110, 7'b1001100);
        repeat (60) @(negedge clk);

        // Four sources: round-robin order and 55-cycle period
        do_reset();
        set_val(0, 1); set_val(1, 22); set_val(2, 333); set_val(3, 4444);
        src_valid = 4'b1111;
        t_prev = 0;
        for (int g = 0; g < 5; g++) begin
            wait_ack("rr", idx, t);
            check("rr_grant", idx, g % 4);
            if (g > 0) check("rr_period", t - t_prev, 55);
            t_prev = t;
        end
        src_valid = '0;
        repeat (60) @(negedge clk);

        // Largest 13-bit value and clamp helper
        do_reset();
        set_val(0, 13'h1FFF);
        src_valid = 4'b0001;
        wait_ack("max", idx, t);
        src_valid = '0;
        repeat (15) @(negedge clk);
        expect_digit("max_thou", 4'b0111, 7'b0000000);
        expect_digit("max_hund", 4'b1011, 7'b1001111);
        expect_digit("max_tens", 4'b1101, 7'b0000100);
        expect_digit("max_ones", 4'b1110, 7'b1001111);
        check("clamp_10000", int'(clamp_dec(32'd10000)), 9999);
        check("clamp_9999", int'(clamp_dec(32'd9999)), 9999);
        check("clamp_8191", int'(clamp_dec(32'd8191)), 8191);
        repeat (50) @(negedge clk);

        // Only source 2: wrap from ptr 3, live re-capture, then drop
        do_reset();
        set_val(2, 567);
        src_valid = 4'b0100;
        wait_ack("wrap1", idx, t_prev);
        check("wrap1_grant", idx, 2);
        set_val(2, 890);
        wait_ack("wrap2", idx, t);
        check("wrap2_grant", idx, 2);
        check("wrap2_period", t - t_prev, 55);
        repeat (20) @(negedge clk);
        src_valid = '0;
        acks = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (src_ack != '0) acks++;
        end
        check("drop_no_ack", acks, 0);
        expect_digit("drop_thou", 4'b0111, 7'b0000001);
        expect_digit("drop_hund", 4'b1011, 7'b0000000);
        expect_digit("drop_tens", 4'b1101, 7'b0000100);
        expect_digit("drop_ones", 4'b1110, 7'b0000001);

        // Reset during conversion clears pointer and display
        do_reset();
        set_val(0, 4321); set_val(1, 1111);
        src_valid = 4'b0001;
        wait_ack("pre", idx, t);
        src_valid = '0;
        repeat (60) @(negedge clk);
        src_valid = 4'b0010;
        wait_ack("mid", idx, t);
        check("mid_grant", idx, 1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_anode", int'(Anode), 4'hF);
        check("midrst_led", int'(LED_out), 7'h7F);
        check("midrst_ack", int'(src_ack), 0);
        check("midrst_cur", int'(cur_src), 0);
        rst = 1'b0;
        src_valid = 4'b0011;
        wait_ack("post", idx, t);
        check("post_grant_ptr0", idx, 0);
        src_valid = '0;
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
